// File: rtl/axis_1_to_n_manifold.sv
// ---------------------------------------------------------------------------
// axis_1_to_n_manifold
//
// Per-packet AXI4-Stream fan-out. One input stream is copied into
// NUM_OUTPUTS independently buffered output streams. The first beat of each
// packet carries a destination bitmap in tuser[DST_OFFSET +: NUM_OUTPUTS].
// Every beat of that packet is written only into the queues whose bitmap
// bit is set. Bitmap bits on later beats are ignored.
//
// Data path: input beat -> one register stage -> per-output fall-through
// queue. A beat accepted in cycle N is written in cycle N+1 and shows up on
// the selected outputs in cycle N+2.
//
// Optional feature macro: AXIS_MANIFOLD_ZERO_BROADCAST_EN
//   defined   : a zero bitmap is treated as all-ones (broadcast) and
//               pkt_dropped is tied low.
//   undefined : a zero-bitmap packet is accepted and written nowhere, and
//               pkt_dropped pulses in the cycle after its last beat.
//
// Ports:
//   axis_aclk, axis_resetn   clock, asynchronous active-low reset
//   axis_input_*             input stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   axis_output_*            NUM_OUTPUTS packed output streams, output i at
//                            slice i of each bus
//   pkt_dropped              one-cycle pulse when a dropped packet ends
// ---------------------------------------------------------------------------
module axis_1_to_n_manifold #(
    parameter int TDATA_WIDTH     = 256,
    parameter int TUSER_WIDTH     = 128,
    parameter int NUM_OUTPUTS     = 4,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int DST_OFFSET      = 24
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_resetn,

    input  logic [TDATA_WIDTH-1:0]                 axis_input_tdata,
    input  logic [TDATA_WIDTH/8-1:0]               axis_input_tkeep,
    input  logic [TUSER_WIDTH-1:0]                 axis_input_tuser,
    input  logic                                   axis_input_tvalid,
    output logic                                   axis_input_tready,
    input  logic                                   axis_input_tlast,

    output logic [NUM_OUTPUTS*TDATA_WIDTH-1:0]     axis_output_tdata,
    output logic [NUM_OUTPUTS*TDATA_WIDTH/8-1:0]   axis_output_tkeep,
    output logic [NUM_OUTPUTS*TUSER_WIDTH-1:0]     axis_output_tuser,
    output logic [NUM_OUTPUTS-1:0]                 axis_output_tvalid,
    input  logic [NUM_OUTPUTS-1:0]                 axis_output_tready,
    output logic [NUM_OUTPUTS-1:0]                 axis_output_tlast,

    output logic                                   pkt_dropped
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_WIDTH  = FIFO_DEPTH_BITS + 1;

    // Queue level at which the input is throttled, and the level one below
    // it that already counts as throttling while a write is in flight.
    localparam logic [CNT_WIDTH-1:0] NF_LEVEL     = CNT_WIDTH'(DEPTH - 2);
    localparam logic [CNT_WIDTH-1:0] NF_LEVEL_PRE = CNT_WIDTH'(DEPTH - 3);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;

    logic                     r_outOfReset;
    logic [NUM_OUTPUTS-1:0]   r_dstMask;
    logic [NUM_OUTPUTS-1:0]   w_bitmap;
    logic [NUM_OUTPUTS-1:0]   w_firstMask;
    logic [NUM_OUTPUTS-1:0]   w_beatMask;
    logic [NUM_OUTPUTS-1:0]   w_nearlyFull;
    logic                     w_accept;

    logic [NUM_OUTPUTS-1:0]   r_wrEn;
    logic [TDATA_WIDTH-1:0]   r_data;
    logic [KEEP_WIDTH-1:0]    r_keep;
    logic [TUSER_WIDTH-1:0]   r_user;
    logic                     r_last;

    // Input is held off during reset and for the first edge after release,
    // and whenever any queue is close to full, regardless of which queues
    // the current packet targets.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_outOfReset <= 1'b0;
        end else begin
            r_outOfReset <= 1'b1;
        end
    end

    assign axis_input_tready = r_outOfReset && !(|w_nearlyFull);
    assign w_accept          = axis_input_tvalid && axis_input_tready;
    assign w_bitmap          = axis_input_tuser[DST_OFFSET +: NUM_OUTPUTS];

`ifdef AXIS_MANIFOLD_ZERO_BROADCAST_EN
    assign w_firstMask = (w_bitmap == '0) ? '1 : w_bitmap;
`else
    assign w_firstMask = w_bitmap;
`endif

    // Packet framing state register.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // In IDLE the beat on the bus is a packet start and routes on its own
    // bitmap; inside a packet every beat follows the latched mask.
    always_comb begin
        w_stateNext = r_state;
        w_beatMask  = r_dstMask;
        case (r_state)
            IDLE: begin
                w_beatMask = w_firstMask;
                if (w_accept && !axis_input_tlast) begin
                    w_stateNext = IN_PKT;
                end
            end
            IN_PKT: begin
                if (w_accept && axis_input_tlast) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Destination mask captured from the first beat of each packet.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_dstMask <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_dstMask <= w_firstMask;
        end
    end

    // Single register stage between the input and the queues; r_wrEn holds
    // the per-queue write strobes for the registered beat.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_wrEn <= '0;
            r_data <= '0;
            r_keep <= '0;
            r_user <= '0;
            r_last <= 1'b0;
        end else begin
            r_wrEn <= w_accept ? w_beatMask : '0;
            if (w_accept) begin
                r_data <= axis_input_tdata;
                r_keep <= axis_input_tkeep;
                r_user <= axis_input_tuser;
                r_last <= axis_input_tlast;
            end
        end
    end

`ifdef AXIS_MANIFOLD_ZERO_BROADCAST_EN
    assign pkt_dropped = 1'b0;
`else
    logic r_pktDropped;

    // A packet with an empty mask is consumed silently; flag it once its
    // last beat has been taken.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_pktDropped <= 1'b0;
        end else begin
            r_pktDropped <= w_accept && axis_input_tlast && (w_beatMask == '0);
        end
    end

    assign pkt_dropped = r_pktDropped;
`endif

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_queue
        logic [TDATA_WIDTH-1:0]     r_memData [DEPTH];
        logic [KEEP_WIDTH-1:0]      r_memKeep [DEPTH];
        logic [TUSER_WIDTH-1:0]     r_memUser [DEPTH];
        logic                       r_memLast [DEPTH];
        logic [FIFO_DEPTH_BITS-1:0] r_wrPtr;
        logic [FIFO_DEPTH_BITS-1:0] r_rdPtr;
        logic [CNT_WIDTH-1:0]       r_count;
        logic                       w_push;
        logic                       w_pop;

        assign w_push = r_wrEn[g];
        assign w_pop  = (r_count != '0) && axis_output_tready[g];

        // Storage needs no reset: a flush only has to clear the pointers
        // and the occupancy count.
        always_ff @(posedge axis_aclk) begin
            if (w_push) begin
                r_memData[r_wrPtr] <= r_data;
                r_memKeep[r_wrPtr] <= r_keep;
                r_memUser[r_wrPtr] <= r_user;
                r_memLast[r_wrPtr] <= r_last;
            end
        end

        // Pointers and occupancy; a push and pop in the same cycle leave the
        // count unchanged.
        always_ff @(posedge axis_aclk or negedge axis_resetn) begin
            if (!axis_resetn) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + FIFO_DEPTH_BITS'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + FIFO_DEPTH_BITS'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                    2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // The beat sitting in the register stage is counted as already
        // occupying the queue, so a stalled output accepts exactly
        // DEPTH-2 beats before the input is throttled.
        assign w_nearlyFull[g] = (r_count >= NF_LEVEL) ||
                                 (w_push && (r_count >= NF_LEVEL_PRE));

        assign axis_output_tdata[g*TDATA_WIDTH +: TDATA_WIDTH] = r_memData[r_rdPtr];
        assign axis_output_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH]   = r_memKeep[r_rdPtr];
        assign axis_output_tuser[g*TUSER_WIDTH +: TUSER_WIDTH] = r_memUser[r_rdPtr];
        assign axis_output_tlast[g]                            = r_memLast[r_rdPtr];
        assign axis_output_tvalid[g]                           = (r_count != '0);
    end

endmodule
